// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBrk
    } state_e;

    state_e          state;
    logic [CntW-1:0] bcnt;
    logic [2:0]      bidx;
    logic [7:0]      shreg;
    logic            rx_meta;
    logic            rs;
`ifdef UART_RX_PARITY_EN
    logic            par_ok;
`endif

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rs      <= 1'b1;
        end else begin
            rx_meta <= rx;
            rs      <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            bcnt      <= '0;
            bidx      <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_ok    <= 1'b1;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            // A delivery in StStop below overrides this consume.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                StIdle: begin
                    if (!rs) begin
                        state <= StStart;
                        bcnt  <= '0;
                        busy  <= 1'b1;
                    end
                end

                StStart: begin
                    if (bcnt == HalfCnt) begin
                        bcnt <= '0;
                        if (rs) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else begin
                            state <= StData;
                            bidx  <= '0;
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end

                StData: begin
                    if (bcnt == FullCnt) begin
                        bcnt        <= '0;
                        shreg[bidx] <= rs;
                        if (bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end else begin
                            bidx <= bidx + 3'd1;
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (bcnt == FullCnt) begin
                        bcnt   <= '0;
                        par_ok <= ~(^{shreg, rs});
                        state  <= StStop;
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end
`endif

                StStop: begin
                    if (bcnt == FullCnt) begin
                        bcnt <= '0;
                        if (!rs) begin
                            frame_err <= 1'b1;
                            state     <= StBrk;
                        end else begin
                            state <= StIdle;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (!par_ok) begin
                                frame_err <= 1'b1;
                            end else
`endif
                            if (!valid || ready) begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end else begin
                        bcnt <= bcnt + 1'b1;
                    end
                end

                // Hold off until the line returns high so a break is not seen as 0x00 bytes.
                StBrk: begin
                    if (rs) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
